// File: rtl/hub_node_tx_pkg.sv
// Shared types and constants for the hub node transmit path.
// Header layout: [7:6] dest, [5:4] src, [3:0] len.
package hub_node_tx_pkg;

    localparam int NODE_W      = 2;
    localparam int LEN_W       = 4;
    localparam int HDR_W       = 8;
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_SRC_LSB = 4;
    localparam int HDR_DST_LSB = 6;

    localparam int PAY_DEPTH  = 8;
    localparam int DESC_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [NODE_W-1:0] dest;
        logic [LEN_W-1:0]  len;
    } desc_t;

    function automatic logic [HDR_W-1:0] make_hdr(
        input logic [NODE_W-1:0] dst,
        input logic [NODE_W-1:0] src,
        input logic [LEN_W-1:0]  len
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_DST_LSB +: NODE_W] = dst;
        h[HDR_SRC_LSB +: NODE_W] = src;
        h[HDR_LEN_LSB +: LEN_W]  = len;
        return h;
    endfunction

endpackage

// File: rtl/hub_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read combinationally.
// Ports: push/din, pop/dout, level (0..DEPTH). DEPTH must be a power of 2.
module hub_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    // Wrap bits differ with equal index bits -> full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hub_node_tx.sv
// Store-and-forward packetiser: host words in, header + payload flits out.
// Ports: in_* host stream, out_* hub stream, drop_err, pkt_sent.
import hub_node_tx_pkg::*;

module hub_node_tx #(
    parameter int          DATA_W  = 8,
    parameter logic [1:0]  NODE_ID = 2'd0,
    parameter int          MAX_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [1:0]        in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              drop_err,
    output logic [7:0]        pkt_sent
);

    localparam int PW      = DATA_W + 1;
    localparam int DW      = $bits(desc_t);
    localparam int PAY_LW  = $clog2(PAY_DEPTH) + 1;
    localparam int DESC_LW = $clog2(DESC_DEPTH) + 1;

    logic              rdy_q;
    logic              drop_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [NODE_W-1:0] dest_q;
    logic [NODE_W-1:0] cur_dest;

    logic              accept;
    logic              last_f;
    logic              pay_push;
    logic              desc_push;
    logic              pay_pop;
    logic              desc_pop;

    logic [PW-1:0]     pay_din;
    logic [PW-1:0]     pay_dout;
    logic [PAY_LW-1:0] pay_level;
    logic              pay_full;
    logic              pay_last;

    desc_t              desc_din;
    desc_t              desc_dout;
    logic [DESC_LW-1:0] desc_level;
    logic               desc_full;
    logic               desc_empty;

    tx_state_e state;
    logic      hs;

    // ---------------- write side ----------------

    assign pay_full   = (pay_level == PAY_LW'(PAY_DEPTH));
    assign desc_full  = (desc_level == DESC_LW'(DESC_DEPTH));
    assign desc_empty = (desc_level == '0);

    // rdy_q holds in_ready low while reset is asserted.
    assign in_ready = rdy_q && ((!pay_full && !desc_full) || drop_q);
    assign accept   = in_valid && in_ready;

    assign cnt_nxt  = cnt_q + 1'b1;
    assign cur_dest = (cnt_q == '0) ? in_dest : dest_q;

    // The MAX_LEN-th word closes the packet even without in_last.
    assign last_f    = in_last || (cnt_nxt == LEN_W'(MAX_LEN));
    assign pay_push  = accept && !drop_q;
    assign desc_push = pay_push && last_f;

    assign pay_din       = {last_f, in_data};
    assign desc_din.dest = cur_dest;
    assign desc_din.len  = cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q    <= 1'b0;
            drop_q   <= 1'b0;
            drop_err <= 1'b0;
            cnt_q    <= '0;
            dest_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                if (drop_q) begin
                    if (in_last) drop_q <= 1'b0;
                end else if (last_f) begin
                    cnt_q <= '0;
                    if (!in_last) begin
                        drop_q   <= 1'b1;
                        drop_err <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_nxt;
                    if (cnt_q == '0) dest_q <= in_dest;
                end
            end
        end
    end

    hub_sync_fifo #(
        .W     (PW),
        .DEPTH (PAY_DEPTH)
    ) u_pay_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pay_push),
        .din   (pay_din),
        .pop   (pay_pop),
        .dout  (pay_dout),
        .level (pay_level)
    );

    hub_sync_fifo #(
        .W     (DW),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (desc_push),
        .din   (desc_din),
        .pop   (desc_pop),
        .dout  (desc_dout),
        .level (desc_level)
    );

    // ---------------- read side ----------------

    assign pay_last = pay_dout[PW-1];
    assign hs       = out_valid && out_ready;
    assign pay_pop  = (state == ST_PAYLOAD) && hs;
    assign desc_pop = pay_pop && pay_last;

    // A descriptor only exists once its last word is stored, so
    // HEADER/PAYLOAD never see an empty payload FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            pkt_sent  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!desc_empty) begin
                        state     <= ST_HEADER;
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (out_ready) begin
                        state   <= ST_PAYLOAD;
                        out_sop <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_ready && pay_last) begin
                        pkt_sent <= pkt_sent + 8'd1;
                        // Head descriptor is the one being retired.
                        if (desc_level > DESC_LW'(1)) begin
                            state   <= ST_HEADER;
                            out_sop <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        out_eop  = 1'b0;
        unique case (state)
            ST_HEADER: begin
                out_data = DATA_W'(make_hdr(desc_dout.dest, NODE_ID,
                                            desc_dout.len));
            end
            ST_PAYLOAD: begin
                out_data = pay_dout[DATA_W-1:0];
                out_eop  = pay_last;
            end
            default: begin
                out_data = '0;
                out_eop  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hub_node_tx.sv
// Directed bench for hub_node_tx: latency, backpressure, oversize drop,
// stall stability, mid-packet reset and packet counter wrap.
module tb_hub_node_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic [1:0] in_dest = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       drop_err;
    logic [7:0] pkt_sent;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic       stalled = 1'b0;
    logic [9:0] held = '0;

    always #5 clk = ~clk;

    hub_node_tx #(
        .DATA_W  (8),
        .NODE_ID (2'd0),
        .MAX_LEN (8)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .drop_err  (drop_err),
        .pkt_sent  (pkt_sent)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] fl(input logic s, input logic e,
                                      input logic [7:0] d);
        return {s, e, d};
    endfunction

    // Flit monitor plus hold-stable check while the hub stalls.
    always @(negedge clk) begin
        if (rst_n && stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_flit", 32'({out_sop, out_eop, out_data}),
                  32'(held));
        end
        stalled <= rst_n && out_valid && !out_ready;
        held    <= {out_sop, out_eop, out_data};
        if (rst_n && out_valid && out_ready)
            got_q.push_back({out_sop, out_eop, out_data});
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] d, input logic l,
                             input logic [1:0] ds);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_dest  = ds;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() < n)
            check("drain_timeout", 32'(got_q.size()), 32'(n));
        repeat (6) @(negedge clk);
        check("flit_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("flit[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Values while reset is held.
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sop", 32'(out_sop), 32'd0);
        check("rst_out_eop", 32'(out_eop), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
        @(posedge clk);
        #1;

        // Single packet, dest 3, plus min latency.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(fl(1, 0, 8'hC2));
        exp_q.push_back(fl(0, 0, 8'hA1));
        exp_q.push_back(fl(0, 1, 8'hA2));
        push_word(8'hA1, 1'b0, 2'd3);
        push_word(8'hA2, 1'b1, 2'd3);
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_data", 32'(out_data), 32'hC2);
        check("lat_n2_sop", 32'(out_sop), 32'd1);
        check("lat_n2_eop", 32'(out_eop), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(3);
        check("single_pkt_sent", 32'(pkt_sent), 32'd1);

        // Four 2-word packets into a stalled hub.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(fl(1, 0, 8'((i << 6) | 2)));
            exp_q.push_back(fl(0, 0, 8'(8'h10 + 2 * i)));
            exp_q.push_back(fl(0, 1, 8'(8'h11 + 2 * i)));
            push_word(8'(8'h10 + 2 * i), 1'b0, 2'(i));
            push_word(8'(8'h11 + 2 * i), 1'b1, 2'(i));
        end
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(12);
        check("burst_pkt_sent", 32'(pkt_sent), 32'd4);

        // Oversize packet, dest sampled on first word only.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(fl(1, 0, 8'h48));
        for (int i = 0; i < 8; i++)
            exp_q.push_back(fl(0, 1'(i == 7), 8'(8'h30 + i)));
        exp_q.push_back(fl(1, 0, 8'h81));
        exp_q.push_back(fl(0, 1, 8'h55));
        for (int i = 0; i < 10; i++)
            push_word(8'(8'h30 + i), 1'(i == 9), (i == 0) ? 2'd1 : 2'd3);
        push_word(8'h55, 1'b1, 2'd2);
        drain(11);
        check("drop_err_set", 32'(drop_err), 32'd1);
        check("drop_pkt_sent", 32'(pkt_sent), 32'd2);

        // Hub ready toggling every cycle.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(fl(1, 0, 8'h03));
        exp_q.push_back(fl(0, 0, 8'h71));
        exp_q.push_back(fl(0, 0, 8'h72));
        exp_q.push_back(fl(0, 1, 8'h73));
        exp_q.push_back(fl(1, 0, 8'h81));
        exp_q.push_back(fl(0, 1, 8'h74));
        fork
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
            begin
                push_word(8'h71, 1'b0, 2'd0);
                push_word(8'h72, 1'b0, 2'd0);
                push_word(8'h73, 1'b1, 2'd0);
                push_word(8'h74, 1'b1, 2'd2);
            end
        join
        out_ready = 1'b1;
        drain(6);
        check("toggle_pkt_sent", 32'(pkt_sent), 32'd2);

        // Reset in the middle of a packet with one queued.
        do_reset();
        out_ready = 1'b0;
        push_word(8'h21, 1'b1, 2'd0);
        push_word(8'h22, 1'b0, 2'd1);
        push_word(8'h23, 1'b0, 2'd1);
        push_word(8'h24, 1'b0, 2'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sop", 32'(out_sop), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_pkt_sent", 32'(pkt_sent), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        exp_q.push_back(fl(1, 0, 8'h42));
        exp_q.push_back(fl(0, 0, 8'h66));
        exp_q.push_back(fl(0, 1, 8'h67));
        push_word(8'h66, 1'b0, 2'd1);
        push_word(8'h67, 1'b1, 2'd1);
        drain(3);
        check("postrst_pkt_sent", 32'(pkt_sent), 32'd1);
        check("postrst_drop_err", 32'(drop_err), 32'd0);

        // 256 one-word packets: counter wraps to zero.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(fl(1, 0, 8'(((i % 4) << 6) | 1)));
            exp_q.push_back(fl(0, 1, 8'(i)));
            push_word(8'(i), 1'b1, 2'(i % 4));
        end
        drain(512);
        check("wrap_pkt_sent", 32'(pkt_sent), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hub_node_tx.md
HUB_NODE_TX -- requirements
Module: hub_node_tx

Interface
REQ-001 Parameter DATA_W, default 8, flit width in bits.
REQ-002 Parameter NODE_ID, default 2'd0, source address placed in every header.
REQ-003 Parameter MAX_LEN, default 8, maximum payload words per packet (1..8).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  host payload word valid.
REQ-007 in_ready  output  1  block accepts word when in_valid && in_ready.
REQ-008 in_data  input  DATA_W  payload word.
REQ-009 in_last  input  1  marks final word of packet.
REQ-010 in_dest  input  2  destination node; sampled on first word of each packet only.
REQ-011 out_valid  output  1  flit to hub valid.
REQ-012 out_ready  input  1  hub accepts flit when out_valid && out_ready.
REQ-013 out_data  output  DATA_W  header or payload flit.
REQ-014 out_sop / out_eop  output  1 each  high on header flit / final payload flit.
REQ-015 drop_err  output  1  sticky; set on oversize packet.
REQ-016 pkt_sent  output  8  count of completed packets, wraps 255->0.

Function
REQ-017 Payload FIFO: 8 entries of {in_last, in_data}; descriptor FIFO: 4 entries of {dest[1:0], len[3:0]}.
REQ-018 in_ready = payload FIFO not full && descriptor FIFO not full, or drop mode active.
REQ-019 Write side counts words per packet; on accepted in_last push descriptor {dest, count} and clear count.
REQ-020 Word MAX_LEN accepted without in_last is stored with last flag forced 1, descriptor pushed, drop_err set; following words up to and including in_last are accepted but discarded (drop mode).
REQ-021 Read FSM states IDLE, HEADER, PAYLOAD; IDLE->HEADER when descriptor FIFO non-empty.
REQ-022 HEADER: out_valid=1, out_sop=1, out_data={dest, NODE_ID, len} (8-bit layout [7:6] dest, [5:4] src, [3:0] len); on handshake -> PAYLOAD.
REQ-023 PAYLOAD: out_data = payload FIFO head; out_eop = head last flag; pop on handshake; on handshake of eop flit pop descriptor, increment pkt_sent, -> HEADER if another descriptor present, else IDLE.
REQ-024 Packets are never emitted before their last word is stored (store-and-forward); out_valid never drops without a handshake.
REQ-025 Simultaneous push and pop on full FIFO is permitted only when not full gated by in_ready; on empty FIFO the write is visible to the reader the next cycle (1-cycle fall-through latency minimum).
REQ-026 Minimum latency: in_last accepted at cycle N -> header out_valid at N+2.
REQ-027 Pointers are 3-bit (payload) and 2-bit (descriptor) with an extra wrap bit for full/empty.

Reset
REQ-028 reset low asynchronously clears both FIFOs, pointers, word count, drop mode, FSM to IDLE.
REQ-029 During reset: out_valid=0, out_sop=0, out_eop=0, out_data=0, in_ready=0, drop_err=0, pkt_sent=0.
REQ-030 Reset mid-packet discards all partial and queued packets; no flit of them appears afterwards.

Structure
REQ-031 Shared package holds header field positions, NODE address width (2), LEN width (4), FSM state encoding.
REQ-032 One sub-module hub_sync_fifo (parameterised width/depth, full/empty, same clk/reset) instantiated twice.

Verification
REQ-033 Single packet dest=3, words 0xA1,0xA2 -> header 0xC2 (NODE_ID 0) sop, 0xA1, 0xA2 eop; pkt_sent=1.
REQ-034 Four back-to-back 2-word packets with out_ready=0 -> in_ready drops after 8 words; release -> 4 packets in order, pkt_sent=4.
REQ-035 10-word packet -> header len=8, 8 payload flits, last with eop; drop_err=1; words 9-10 absent.
REQ-036 out_ready toggling every cycle -> out_data/out_valid stable while stalled, no flit lost or duplicated.
REQ-037 Assert reset after 3 words of a 5-word packet -> outputs zero; next packet emitted cleanly with pkt_sent=1.
REQ-038 Send 256 one-word packets -> pkt_sent wraps to 0.
